// File: rtl/bcd_pkg.sv
// Shared widths, FSM state type and digit-validity helper for the BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DATA_W     = 20;
  localparam int unsigned ACC_W      = 24;
  localparam int unsigned SREG_W     = BCD_W * NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // True when any packed digit in the word is outside 0..9.
  function automatic logic any_invalid(input logic [SREG_W-1:0] digits);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digits[i*BCD_W +: BCD_W] > BCD_W'(9)) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: result_c = acc*10 + digit.
module bcd_mac10
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [BCD_W-1:0] digit,
  output logic [ACC_W-1:0] result_c
);

  logic [ACC_W-1:0] times8;
  logic [ACC_W-1:0] times2;

  assign times8   = acc << 3;
  assign times2   = acc << 1;
  assign result_c = times8 + times2 + ACC_W'(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential six-digit BCD to 20-bit binary converter, one digit per clock, MSD first.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [BCD_W-1:0]  unit,
  input  logic [BCD_W-1:0]  ten,
  input  logic [BCD_W-1:0]  hun,
  input  logic [BCD_W-1:0]  tho,
  input  logic [BCD_W-1:0]  t_tho,
  input  logic [BCD_W-1:0]  h_hun,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  state_t             state, state_d;
  logic [ACC_W-1:0]   acc, acc_d, mac_c;
  logic [SREG_W-1:0]  sreg, sreg_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               busy_d, done_d;
  logic [DATA_W-1:0]  data_d;
`ifdef BCD_DIGIT_CHECK_EN
  logic               invalid, invalid_d, err_d;
`endif

  bcd_mac10 u_mac10 (
    .acc      (acc),
    .digit    (sreg[SREG_W-1 -: BCD_W]),
    .result_c (mac_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    sreg_d    = sreg;
    cnt_d     = cnt;
    busy_d    = busy;
    done_d    = 1'b0;
    data_d    = data;
`ifdef BCD_DIGIT_CHECK_EN
    invalid_d = invalid;
    err_d     = err;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          sreg_d  = {h_hun, t_tho, tho, hun, ten, unit};
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          invalid_d = any_invalid({h_hun, t_tho, tho, hun, ten, unit});
          err_d     = 1'b0;
`endif
        end
      end
      CALC: begin
        acc_d  = mac_c;
        sreg_d = sreg << BCD_W;
        cnt_d  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = DATA_W'(mac_c);
`ifdef BCD_DIGIT_CHECK_EN
          if (invalid) begin
            data_d = '0;
            err_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      acc   <= '0;
      sreg  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      data  <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      invalid <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      state <= state_d;
      acc   <= acc_d;
      sreg  <= sreg_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      done  <= done_d;
      data  <= data_d;
`ifdef BCD_DIGIT_CHECK_EN
      invalid <= invalid_d;
      err     <= err_d;
`endif
    end
  end

`ifndef BCD_DIGIT_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomised and directed bench for bcd_to_bin against a positional-weight reference model.
module tb_bcd_to_bin;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [3:0]  unit, ten, hun, tho, t_tho, h_hun;
  logic        busy, done, err;
  logic [19:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_bin dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .unit    (unit),
    .ten     (ten),
    .hun     (hun),
    .tho     (tho),
    .t_tho   (t_tho),
    .h_hun   (h_hun),
    .busy    (busy),
    .done    (done),
    .data    (data),
    .err     (err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sum of digit * 10^position, independent of the shift-add structure.
  function automatic logic [20:0] ref_conv(input logic [23:0] dig);
    int unsigned v, w;
    logic [3:0]  d;
    logic        bad;
    v = 0; w = 1; bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = dig[4*i +: 4];
      v += d * w;
      w *= 10;
      if (d > 4'd9) bad = 1'b1;
    end
`ifdef BCD_DIGIT_CHECK_EN
    if (bad) return {1'b1, 20'd0};
`endif
    return {1'b0, v[19:0]};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_digits(input logic [23:0] dig);
    {h_hun, t_tho, tho, hun, ten, unit} = dig;
  endtask

  task automatic start_conv(input string tag, input logic [23:0] dig);
    set_digits(dig);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_done0"}, 32'(done), 32'd0);
  endtask

  // Waits (bounded) for done; "already" cycles since the accept were stepped by the caller.
  task automatic wait_done(input string tag, input int already,
                           input logic [19:0] exp_data, input logic exp_err);
    int lat, busy_cnt;
    lat = already;
    busy_cnt = already;
    while (lat < 14) begin
      step();
      lat++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"},  32'(lat), 32'd6);
    check({tag, "_busy"}, 32'(busy_cnt), 32'd5);
    check({tag, "_bsyd"}, 32'(busy), 32'd0);
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_err"},  32'(err), 32'(exp_err));
  endtask

  task automatic hold_check(input string tag, input logic [19:0] exp_data);
    step();
    check({tag, "_dlow"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(data), 32'(exp_data));
  endtask

  logic [23:0] dig;
  logic [20:0] exp_v;

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    set_digits(24'h0);
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    sys_rst = 1'b0;
    step();

    start_conv("c123456", 24'h123456);
    wait_done("c123456", 0, 20'd123456, 1'b0);
    hold_check("c123456", 20'd123456);

    start_conv("c999999", 24'h999999);
    wait_done("c999999", 0, 20'd999999, 1'b0);
    hold_check("c999999", 20'd999999);

    start_conv("c000000", 24'h000000);
    wait_done("c000000", 0, 20'd0, 1'b0);
    hold_check("c000000", 20'd0);

    // Start during conversion is ignored.
    start_conv("ign", 24'h654321);
    step(); step();
    set_digits(24'h987654);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_busy3", 32'(busy), 32'd1);
    wait_done("ign", 3, 20'd654321, 1'b0);
    // Start in the done cycle is accepted at the next edge.
    start_conv("b2b", 24'h987654);
    wait_done("b2b", 0, 20'd987654, 1'b0);

    // Digit changes after acceptance do not affect the result.
    start_conv("chg", 24'h204060);
    set_digits(24'h111111);
    wait_done("chg", 0, 20'd204060, 1'b0);
    hold_check("chg", 20'd204060);

    // Reset mid-conversion aborts it.
    start_conv("rmid", 24'h345678);
    step(); step(); step();
    sys_rst = 1'b1;
    step();
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_data", 32'(data), 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    sys_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rmid_nodone", 32'(done), 32'd0);
    end

    // Invalid digit in the tens position, then a valid small value.
    exp_v = ref_conv(24'h0000A0);
    start_conv("inv", 24'h0000A0);
    wait_done("inv", 0, exp_v[19:0], exp_v[20]);
    hold_check("inv", exp_v[19:0]);
    check("inv_errhold", 32'(err), 32'(exp_v[20]));
    start_conv("v42", 24'h000042);
    check("v42_errclr", 32'(err), 32'd0);
    wait_done("v42", 0, 20'd42, 1'b0);

    // Randomised conversions, occasionally with out-of-range digits.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 6; i++) begin
        if (n % 4 == 3) dig[4*i +: 4] = 4'($urandom_range(0, 15));
        else            dig[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      exp_v = ref_conv(dig);
      start_conv("rnd", dig);
      if ($urandom_range(0, 1) == 1) set_digits(24'($urandom));
      wait_done("rnd", 0, exp_v[19:0], exp_v[20]);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) hold_check("rnd", exp_v[19:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
